// File: rtl/mult_pkg.sv
// Purpose : shared width constant and operand/product types for the mantissa multiplier.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: MULT_N (default operand width), operand_t, product_t.
package mult_pkg;

  localparam int MULT_N = 16;

  typedef logic [MULT_N-1:0]   operand_t;
  typedef logic [2*MULT_N-1:0] product_t;

endpackage : mult_pkg

// File: rtl/mult_pp_row.sv
// Purpose : one array-multiplier row: gates multiplicand a by one multiplier bit and
//           ripple-adds it onto the running N-bit accumulator from the row above.
// Latency : combinational. Backpressure : none.
// Ports   : a [N-1:0] multiplicand, b_bit multiplier bit for this row,
//           acc_in [N-1:0] running sum (already shifted right by one row),
//           sum [N:0] row result; sum[0] is a final product bit, sum[N] is the carry-out.
module mult_pp_row
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic [N-1:0] a,
  input  logic         b_bit,
  input  logic [N-1:0] acc_in,
  output logic [N:0]   sum
);

  logic [N-1:0] pp;

  assign pp = a & {N{b_bit}};

  // Full-adder chain; the carry is a loop-local variable so the ripple is
  // expressed as ordered procedural steps rather than a self-referencing vector.
  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum[k] = pp[k] ^ acc_in[k] ^ c;
      c      = (pp[k] & acc_in[k]) | (pp[k] & c) | (acc_in[k] & c);
    end
    // Carry-out becomes the row's MSB.
    sum[N] = c;
  end

endmodule : mult_pp_row

// File: rtl/mult_16bits.sv
// Purpose : unsigned N x N array multiplier, full 2N-bit product, plus a registered copy.
// Latency : OUT combinational (0 cycles); OUT_REG 1 cycle. Backpressure : none, no enable/handshake.
// Ports   : clock, reset_n (async active-low), A/B [N-1:0] operands,
//           OUT [2N-1:0] = A*B, OUT_REG [2N-1:0] = OUT delayed one clock, cleared by reset.
// Config  : define MULT16_CHECK_EN to add a simulation-only self-check of OUT and OUT_REG.
module mult_16bits
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic [2*N-1:0]   OUT,
  output logic [2*N-1:0]   OUT_REG
);

  logic [N-1:0]   pp0;
  logic [N-1:0]   acc0;
  logic [2*N-1:0] prod;

  // Row 0 needs no adder: its LSB is product bit 0 and the rest seeds the chain.
  assign pp0     = A & {N{B[0]}};
  assign prod[0] = pp0[0];
  assign acc0    = {1'b0, pp0[N-1:1]};

  // Rows 1..N-1. Each row retires one product bit (sum[0]) and passes its
  // upper N bits down as the next accumulator; the last row's upper bits are
  // the top half of the product.
  for (genvar i = 1; i < N; i++) begin : g_row
    logic [N-1:0] acc_in;
    logic [N:0]   sum;

    if (i == 1) begin : g_first
      assign acc_in = acc0;
    end else begin : g_next
      assign acc_in = g_row[i-1].sum[N:1];
    end

    mult_pp_row #(.N(N)) u_row (
      .a      (A),
      .b_bit  (B[i]),
      .acc_in (acc_in),
      .sum    (sum)
    );

    assign prod[i] = sum[0];

    if (i == N-1) begin : g_last
      assign prod[2*N-1:N] = sum[N:1];
    end
  end

  assign OUT = prod;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      OUT_REG <= '0;
    end else begin
      OUT_REG <= prod;
    end
  end

`ifdef MULT16_CHECK_EN
  // Reference product; simulation only, never synthesised.
  logic [2*N-1:0] chk_exp;
  assign chk_exp = {{N{1'b0}}, A} * {{N{1'b0}}, B};

  chk_out : assert property (@(posedge clock) OUT == chk_exp)
    else $error("mult_16bits: A=%h B=%h OUT=%h expected=%h", A, B, OUT, chk_exp);

  // Sampled values: OUT_REG seen at this edge was loaded at the previous edge.
  chk_out_reg : assert property (@(posedge clock)
      (reset_n && $past(reset_n)) |-> (OUT_REG == $past(chk_exp)))
    else $error("mult_16bits: OUT_REG=%h expected=%h", OUT_REG, $past(chk_exp));
`endif

endmodule : mult_16bits

// File: tb/tb_mult_16bits.sv
module tb_mult_16bits;
  import mult_pkg::*;

  logic     clock;
  logic     reset_n;
  operand_t a;
  operand_t b;
  product_t out_c;
  product_t out_r;

  int vectors;
  int miscompares;

  mult_16bits #(.N(MULT_N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .A       (a),
    .B       (b),
    .OUT     (out_c),
    .OUT_REG (out_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic product_t model_prod(input operand_t x, input operand_t y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return product_t'(p);
  endfunction

  // Inputs change 1 time unit after the rising edge, away from flop sampling.
  task automatic drive(input operand_t x, input operand_t y);
    @(posedge clock);
    #1;
    a = x;
    b = y;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    a = 16'd5;
    b = 16'd7;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (out_c !== 32'd35) begin
      miscompares++;
      $display("FAIL reset_out: got %h want %h", out_c, 32'd35);
    end
    vectors++;
    if (out_r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_out_reg_hold: got %h want %h", out_r, 32'd0);
    end
    // Release between edges; no edge with reset high has happened yet.
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (out_r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_release_pre_edge: got %h want %h", out_r, 32'd0);
    end
    @(negedge clock);
    vectors++;
    if (out_r !== 32'd35) begin
      miscompares++;
      $display("FAIL reset_release_load: got %h want %h", out_r, 32'd35);
    end
    // Asynchronous clear mid-cycle, no clock edge involved.
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (out_r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_async_clear: got %h want %h", out_r, 32'd0);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_boundaries();
    operand_t ta [8];
    operand_t tb_ [8];
    product_t te [8];
    ta[0] = 16'h0000; tb_[0] = 16'hFFFF; te[0] = 32'h0000_0000;
    ta[1] = 16'h0001; tb_[1] = 16'hABCD; te[1] = 32'h0000_ABCD;
    ta[2] = 16'h1234; tb_[2] = 16'h0001; te[2] = 32'h0000_1234;
    ta[3] = 16'hFFFF; tb_[3] = 16'hFFFF; te[3] = 32'hFFFE_0001;
    ta[4] = 16'h8000; tb_[4] = 16'h8000; te[4] = 32'h4000_0000;
    ta[5] = 16'h00FF; tb_[5] = 16'h0101; te[5] = 32'h0000_FFFF;
    ta[6] = 16'hFFFF; tb_[6] = 16'h0002; te[6] = 32'h0001_FFFE;
    ta[7] = 16'hFFFF; tb_[7] = 16'h0000; te[7] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      drive(ta[i], tb_[i]);
      @(negedge clock);
      vectors++;
      if (out_c !== te[i]) begin
        miscompares++;
        $display("FAIL boundary[%0d] A=%h B=%h: got %h want %h", i, ta[i], tb_[i], out_c, te[i]);
      end
    end
  endtask

  task automatic test_random();
    operand_t x;
    operand_t y;
    product_t e;
    for (int i = 0; i < 100; i++) begin
      x = operand_t'($urandom);
      y = operand_t'($urandom);
      e = model_prod(x, y);
      drive(x, y);
      @(negedge clock);
      vectors++;
      if (out_c !== e) begin
        miscompares++;
        $display("FAIL random[%0d] A=%h B=%h: got %h want %h", i, x, y, out_c, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    operand_t x;
    operand_t y;
    product_t e;
    product_t prev_e;
    prev_e = '0;
    for (int i = 0; i < 30; i++) begin
      x = operand_t'($urandom);
      y = operand_t'($urandom_range(0, 3) == 0 ? 32'hFFFF : $urandom);
      e = model_prod(x, y);
      drive(x, y);
      @(negedge clock);
      if (i > 0) begin
        vectors++;
        if (out_r !== prev_e) begin
          miscompares++;
          $display("FAIL pipeline[%0d] OUT_REG: got %h want %h", i, out_r, prev_e);
        end
      end
      vectors++;
      if (out_c !== e) begin
        miscompares++;
        $display("FAIL pipeline[%0d] OUT A=%h B=%h: got %h want %h", i, x, y, out_c, e);
      end
      prev_e = e;
    end
    @(negedge clock);
    vectors++;
    if (out_r !== prev_e) begin
      miscompares++;
      $display("FAIL pipeline_tail OUT_REG: got %h want %h", out_r, prev_e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    a           = '0;
    b           = '0;
    test_reset();
    test_boundaries();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mult_16bits
